// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: control codes and FSM encoding.
// The ALU control decoder uses these same constants.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/mul_step.sv
// One shift-add multiplier iteration: adds the partial products selected by the
// low multiplier bits into the accumulator.
module mul_step #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BITS  = 1
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [BITS-1:0]  i_mbits,
    output logic [WIDTH-1:0] o_acc
);

    logic [WIDTH-1:0] w_sum;

    always_comb begin
        w_sum = i_acc;
        for (int b = 0; b < int'(BITS); b++) begin
            if (i_mbits[b]) begin
                w_sum = w_sum + (i_mcand << b);
            end
        end
    end

    assign o_acc = w_sum;

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle add/sub/and/or, iterative shift-add multiply
// that requests a pipeline stall while it runs. Result and zero flag registered.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH              = 32,
    parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             valid_o,
    output logic             busy_o
);

    localparam int unsigned N     = WIDTH / MUL_BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(N + 1);

    alu_state_t         r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_acc, w_acc_nxt;
    logic [WIDTH-1:0]   r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0]   r_mplier, w_mplier_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic [WIDTH-1:0]   r_data, w_data_nxt;
    logic               r_zero, w_zero_nxt;
    logic               r_valid, w_valid_nxt;
    logic [WIDTH-1:0]   w_alu_res;
    logic [WIDTH-1:0]   w_acc_step;

    mul_step #(
        .WIDTH (WIDTH),
        .BITS  (MUL_BITS_PER_CYCLE)
    ) u_mul_step (
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_mbits (r_mplier[MUL_BITS_PER_CYCLE-1:0]),
        .o_acc   (w_acc_step)
    );

    // Single-cycle datapath; illegal codes yield zero.
    always_comb begin
        w_alu_res = '0;
        case (ALUCtrl_i)
            ALU_ADD: w_alu_res = data1_i + data2_i;
            ALU_SUB: w_alu_res = data1_i - data2_i;
            ALU_AND: w_alu_res = data1_i & data2_i;
            ALU_OR:  w_alu_res = data1_i | data2_i;
            default: w_alu_res = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_data   <= '0;
            r_zero   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_count  <= w_count_nxt;
            r_data   <= w_data_nxt;
            r_zero   <= w_zero_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_count_nxt  = r_count;
        w_data_nxt   = r_data;
        w_zero_nxt   = r_zero;
        w_valid_nxt  = 1'b0;

        if (flush_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_i) begin
                        if (ALUCtrl_i == ALU_MUL) begin
                            w_acc_nxt    = '0;
                            w_mcand_nxt  = data1_i;
                            w_mplier_nxt = data2_i;
                            w_count_nxt  = CNT_W'(N);
                            w_state_nxt  = ST_MUL;
                        end else begin
                            w_data_nxt  = w_alu_res;
                            w_zero_nxt  = (w_alu_res == '0);
                            w_valid_nxt = 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    // Issue requests in this state are held off by the hazard unit.
                    w_acc_nxt    = w_acc_step;
                    w_mcand_nxt  = r_mcand << MUL_BITS_PER_CYCLE;
                    w_mplier_nxt = r_mplier >> MUL_BITS_PER_CYCLE;
                    w_count_nxt  = r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        w_data_nxt  = w_acc_step;
                        w_zero_nxt  = (w_acc_step == '0);
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign data_o  = r_data;
    assign zero_o  = r_zero;
    assign valid_o = r_valid;
    assign busy_o  = (r_state == ST_MUL) ||
                     (valid_i && (ALUCtrl_i == ALU_MUL) && (r_state == ST_IDLE));

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: vector table for single-cycle ops plus
// hand-written multiply, stall, flush and reset sequences.
module tb_alu_multicycle;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        vld;
    logic [2:0]  ctrl;
    logic [31:0] a, b;
    logic [31:0] d_o;
    logic        z_o, v_o, busy;

    logic        vld4;
    logic [2:0]  ctrl4;
    logic [31:0] a4, b4;
    logic [31:0] d4_o;
    logic        z4_o, v4_o, busy4;

    int n_vec = 0;
    int n_err = 0;

    alu_multicycle #(.WIDTH(32), .MUL_BITS_PER_CYCLE(1)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vld), .ALUCtrl_i(ctrl),
        .data1_i(a), .data2_i(b), .data_o(d_o), .zero_o(z_o), .valid_o(v_o), .busy_o(busy)
    );

    alu_multicycle #(.WIDTH(32), .MUL_BITS_PER_CYCLE(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .valid_i(vld4), .ALUCtrl_i(ctrl4),
        .data1_i(a4), .data2_i(b4), .data_o(d4_o), .zero_o(z4_o), .valid_o(v4_o), .busy_o(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_d;
        logic        exp_z;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue a mul on the default DUT and follow it through completion.
    // With hold_add, an add(1,2) is presented during the whole MUL phase.
    task automatic run_mul(input logic [31:0] ma, input logic [31:0] mb,
                           input logic [31:0] exp, input bit hold_add);
        vld = 1'b1; ctrl = 3'b100; a = ma; b = mb;
        #1;
        check("mul busy issue", 32'(busy), 32'd1);
        tick();
        if (hold_add) begin
            ctrl = 3'b000; a = 32'd1; b = 32'd2;
        end else begin
            vld = 1'b0;
        end
        for (int c = 1; c <= 32; c++) begin
            #1;
            check($sformatf("mul busy c%0d", c), 32'(busy), 32'd1);
            check($sformatf("mul no valid c%0d", c), 32'(v_o), 32'd0);
            tick();
        end
        check("mul valid c33", 32'(v_o), 32'd1);
        check("mul data c33", d_o, exp);
        check("mul zero c33", 32'(z_o), 32'(exp == 32'd0));
        #1;
        check("mul busy c33", 32'(busy), 32'd0);
        if (hold_add) begin
            tick();
            vld = 1'b0;
            check("stalled add valid c34", 32'(v_o), 32'd1);
            check("stalled add data c34", d_o, 32'd3);
        end
        vld = 1'b0;
        tick();
        check("post mul idle valid", 32'(v_o), 32'd0);
    endtask

    initial begin
        logic [31:0] held;

        rst = 1'b1; flush = 1'b0; vld = 1'b0; ctrl = '0; a = '0; b = '0;
        vld4 = 1'b0; ctrl4 = '0; a4 = '0; b4 = '0;

        vecs[0] = '{3'b000, 32'd7,         32'd5,         32'd12,        1'b0};
        vecs[1] = '{3'b001, 32'd5,         32'd5,         32'd0,         1'b1};
        vecs[2] = '{3'b010, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  1'b0};
        vecs[3] = '{3'b011, 32'hF0F0F0F0,  32'hFF00FF00,  32'hFFF0FFF0,  1'b0};
        vecs[4] = '{3'b111, 32'h12345678,  32'h9ABCDEF0,  32'd0,         1'b1};
        vecs[5] = '{3'b101, 32'h0000FFFF,  32'h00000001,  32'd0,         1'b1};
        vecs[6] = '{3'b000, 32'hFFFFFFFF,  32'h00000001,  32'd0,         1'b1};
        vecs[7] = '{3'b001, 32'h00000000,  32'h00000001,  32'hFFFFFFFF,  1'b0};

        tick();
        tick();
        rst = 1'b0;
        check("reset data", d_o, 32'd0);
        check("reset zero", 32'(z_o), 32'd0);
        check("reset valid", 32'(v_o), 32'd0);
        check("reset busy", 32'(busy), 32'd0);

        // Back-to-back single-cycle ops: one result per cycle.
        for (int i = 0; i < 8; i++) begin
            vld = 1'b1; ctrl = vecs[i].ctrl; a = vecs[i].a; b = vecs[i].b;
            #1;
            check($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
            tick();
            check($sformatf("vec%0d valid", i), 32'(v_o), 32'd1);
            check($sformatf("vec%0d data", i), d_o, vecs[i].exp_d);
            check($sformatf("vec%0d zero", i), 32'(z_o), 32'(vecs[i].exp_z));
        end
        vld = 1'b0;
        tick();
        check("idle valid low", 32'(v_o), 32'd0);
        check("idle data holds", d_o, 32'hFFFFFFFF);

        // Four-bits-per-cycle build: N=8, result in cycle 9.
        vld4 = 1'b1; ctrl4 = 3'b100; a4 = 32'd12345; b4 = 32'd6789;
        tick();
        vld4 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("mul4 no valid c%0d", c), 32'(v4_o), 32'd0);
            check($sformatf("mul4 busy c%0d", c), 32'(busy4), 32'd1);
            tick();
        end
        check("mul4 valid c9", 32'(v4_o), 32'd1);
        check("mul4 data c9", d4_o, 32'h04FED79D);
        check("mul4 busy c9", 32'(busy4), 32'd0);

        run_mul(32'h00010003, 32'h00020005, 32'h000B000F, 1'b0);
        run_mul(32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, 1'b0);
        run_mul(32'h00000000, 32'h12345678, 32'h00000000, 1'b0);
        run_mul(32'h0000000B, 32'h0000000D, 32'h0000008F, 1'b1);

        // Flush at cycle 10 of a mul: no result ever, outputs hold.
        held = d_o;
        vld = 1'b1; ctrl = 3'b100; a = 32'd3; b = 32'd4;
        tick();
        vld = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush busy c11", 32'(busy), 32'd0);
        for (int c = 11; c <= 40; c++) begin
            check($sformatf("flush no valid c%0d", c), 32'(v_o), 32'd0);
            tick();
        end
        check("flush data hold", d_o, held);
        vld = 1'b1; ctrl = 3'b000; a = 32'd2; b = 32'd2;
        tick();
        vld = 1'b0;
        check("post flush add valid", 32'(v_o), 32'd1);
        check("post flush add data", d_o, 32'd4);

        // Reset at cycle 5 of a mul.
        vld = 1'b1; ctrl = 3'b100; a = 32'd9; b = 32'd9;
        tick();
        vld = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midmul reset data", d_o, 32'd0);
        check("midmul reset zero", 32'(z_o), 32'd0);
        check("midmul reset valid", 32'(v_o), 32'd0);
        check("midmul reset busy", 32'(busy), 32'd0);
        for (int c = 7; c <= 40; c++) begin
            if (v_o !== 1'b0) check($sformatf("reset no valid c%0d", c), 32'(v_o), 32'd0);
            tick();
        end
        check("reset stays quiet", 32'(v_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Execute-stage ALU of the pipelined CPU; consumes the 3-bit ALU control code from the ALU control decoder together with the two ID/EX operands.
- add/sub/and/or complete in one cycle.
- mul runs on an iterative shift-add multiplier over several cycles; the block raises busy_o so the hazard unit holds the pipeline.
- Result and zero flag are registered and go to the EX/MEM register.

Parameters:
- WIDTH, 32, operand and result width.
- MUL_BITS_PER_CYCLE, 1, multiplier bits retired per iteration; power of 2 that divides WIDTH. N = WIDTH/MUL_BITS_PER_CYCLE iterations.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous abort of any in-flight operation.
- valid_i  in  1  operation issued this cycle.
- ALUCtrl_i  in  3  000 add, 001 sub, 010 and, 011 or, 100 mul; 101-111 illegal.
- data1_i  in  WIDTH  operand A (rs).
- data2_i  in  WIDTH  operand B (rt or sign-extended immediate).
- data_o  out  WIDTH  registered result.
- zero_o  out  1  registered (result == 0).
- valid_o  out  1  data_o/zero_o valid this cycle; one-cycle pulse per accepted operation.
- busy_o  out  1  stall request to the hazard unit.

Behaviour:
- Reset (rst_i high at an edge): state IDLE, data_o=0, zero_o=0, valid_o=0, iteration count=0, accumulator=0. Reset overrides flush_i and valid_i in the same cycle.
- States: IDLE and MUL.
- IDLE, valid_i=1, ALUCtrl_i!=100:
  - Result computed combinationally, registered at the edge.
  - valid_o=1 the following cycle; state stays IDLE.
  - Back-to-back issue allowed at one op per cycle.
- IDLE, valid_i=1, ALUCtrl_i=100:
  - Latch multiplicand=data1_i, multiplier=data2_i, accumulator=0, count=N; go to MUL.
- MUL, each cycle:
  - Add the multiplicand shifted partial products for the low MUL_BITS_PER_CYCLE multiplier bits.
  - Shift the multiplicand left and the multiplier right by MUL_BITS_PER_CYCLE; decrement count.
  - When count==1, the final accumulator is registered into data_o, valid_o=1 next cycle, return to IDLE.
- Latency: issue in cycle 0 gives valid_o in cycle 1 for single-cycle ops and in cycle N+1 for mul (N=32 at defaults).
- busy_o is combinational = (state==MUL) OR (valid_i AND ALUCtrl_i==100 AND state==IDLE).
  - High from the issue cycle through cycle N; low in the valid_o cycle, so the next instruction issues in cycle N+1.
- valid_i while in MUL is ignored (the hazard unit holds the instruction); no effect on state or outputs.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH; no overflow flag.
  - mul returns the low WIDTH bits of the product (identical for signed and unsigned).
  - and/or are bitwise.
- Illegal code (101-111) with valid_i: data_o=0, zero_o=1, valid_o=1 next cycle, state stays IDLE.
- zero_o is always updated in the same edge as data_o and reflects the new data_o.
- valid_o=0 in every cycle with no completing operation; data_o/zero_o hold their last value.
- flush_i=1 at an edge (no reset):
  - state goes to IDLE; valid_o=0 next cycle; valid_i in the same cycle is ignored.
  - data_o/zero_o hold. An aborted mul never produces valid_o.
- Reset in mid-MUL: immediate return to IDLE, outputs to reset values, no valid_o.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control localparams ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_MUL=3'b100. The ALU control decoder must use the same constants.
  - The IDLE/MUL state encoding.
- One combinational sub-module, mul_step: inputs accumulator, multiplicand, low multiplier bits; output next accumulator. Instantiated once per cycle-step inside alu_multicycle.

Test Plan:
- Single-cycle ops: valid_i with ALUCtrl 000, A=7, B=5 → cycle 1 data_o=12, zero_o=0, valid_o=1. Next cycle 001, A=5, B=5 → data_o=0, zero_o=1. Then 010 F0F0F0F0 & FF00FF00 → F000F000. Then 011 → FFF0FFF0. Check back-to-back valid_o on four consecutive cycles.
- mul defaults: A=0x00010003, B=0x00020005 → busy_o high cycles 0-32, valid_o only in cycle 33, data_o=0x000B000F. Also A=FFFFFFFF (-1), B=3 → FFFFFFFD.
- Stall interaction: hold valid_i=1 with an add during MUL → no extra valid_o, mul result correct; add accepted in cycle 33 yields valid_o in cycle 34.
- Flush mid-mul: issue mul, assert flush_i at cycle 10 → busy_o low from cycle 11, no valid_o through cycle 40, data_o unchanged. A subsequent add works normally.
- Reset mid-mul: rst_i at cycle 5 → cycle 6 data_o=0, zero_o=0, valid_o=0, busy_o=0.
- Illegal code 111 and MUL_BITS_PER_CYCLE=4 build: illegal gives data_o=0, zero_o=1, valid_o in cycle 1. With MUL_BITS_PER_CYCLE=4, 12345×6789 gives 0x04FED79D with valid_o in cycle 9.
